// File: rtl/pci_pkg.sv
// Shared PCI model definitions: arbiter state encoding, active-low levels,
// device addresses and C/BE command words.
package pci_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        BUSY,
        TURNAROUND
    } arb_state_t;

    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

    localparam logic [31:0] DEVICE_A_ADDRESS = 32'h0000_1000;
    localparam logic [31:0] DEVICE_B_ADDRESS = 32'h0000_2000;
    localparam logic [31:0] DEVICE_C_ADDRESS = 32'h0000_3000;

    localparam logic [3:0] READ_C_BE  = 4'b0110;
    localparam logic [3:0] WRITE_C_BE = 4'b0111;

endpackage

// File: rtl/pci_arbiter_if.sv
// Request/grant and shared bus-activity signals between the arbiter and the devices.
// Devices use the master modport, the arbiter uses the slave modport.
interface pci_arbiter_if #(
    parameter int N_MASTERS = 3
);
    logic [N_MASTERS-1:0]         REQ;
    logic                         FRAME;
    logic                         IRDY;
    logic [N_MASTERS-1:0]         GNT;
    logic [$clog2(N_MASTERS)-1:0] gnt_idx;
    logic                         bus_busy;
    logic                         timeout;

    modport master (
        output REQ, FRAME, IRDY,
        input  GNT, gnt_idx, bus_busy, timeout
    );

    modport slave (
        input  REQ, FRAME, IRDY,
        output GNT, gnt_idx, bus_busy, timeout
    );
endinterface

// File: rtl/pci_rr_picker.sv
// Combinational round-robin winner search: first active request after ptr,
// wrapping modulo N_MASTERS.
module pci_rr_picker #(
    parameter int N_MASTERS = 3
) (
    input  logic [N_MASTERS-1:0]         req,
    input  logic [$clog2(N_MASTERS)-1:0] ptr,
    output logic                         valid,
    output logic [$clog2(N_MASTERS)-1:0] idx
);
    localparam int IW = $clog2(N_MASTERS);

    int cand;

    // Walk from farthest to nearest so the closest requester after ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            cand = (int'(ptr) + i) % N_MASTERS;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Round-robin PCI bus arbiter with grant timeout and registered active-low GNT.
// Define PCI_ARB_PARKING_EN to park the grant on the last master while idle.
module pci_arbiter
    import pci_pkg::*;
#(
    parameter int N_MASTERS   = 3,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    pci_arbiter_if.slave  bus
);
    localparam int         IW       = $clog2(N_MASTERS);
    localparam logic [7:0] CNT_LAST = 8'(GNT_TIMEOUT - 1);

    arb_state_t           state, state_n;
    logic [IW-1:0]        ptr, ptr_n;
    logic [IW-1:0]        idx, idx_n;
    logic [IW-1:0]        win_idx;
    logic                 win_valid;
    logic [7:0]           cnt, cnt_n;
    logic [N_MASTERS-1:0] req_act;
    logic [N_MASTERS-1:0] gnt_q, gnt_n;
    logic                 busy_q, busy_n;
    logic                 timeout_q, timeout_n;
    logic                 frame_low;
    logic                 bus_idle;

    // Undriven (z) or unknown lines count as deasserted, matching the bus pull-ups.
    always_comb begin
        req_act = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            req_act[i] = (bus.REQ[i] === ASSERTED);
        end
        frame_low = (bus.FRAME === ASSERTED);
        bus_idle  = (bus.FRAME !== ASSERTED) && (bus.IRDY !== ASSERTED);
    end

    pci_rr_picker #(
        .N_MASTERS (N_MASTERS)
    ) u_picker (
        .req   (req_act),
        .ptr   (ptr),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IW'(N_MASTERS - 1);
            idx       <= '0;
            cnt       <= '0;
            gnt_q     <= '1;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            gnt_q     <= gnt_n;
            busy_q    <= busy_n;
            timeout_q <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        idx_n     = idx;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
`ifdef PCI_ARB_PARKING_EN
                // A different winner first retargets the parked grant through TURNAROUND.
                if (frame_low) begin
                    state_n = BUSY;
                end else if (win_valid && (win_idx != idx)) begin
                    idx_n   = win_idx;
                    state_n = TURNAROUND;
                end else if (win_valid) begin
                    ptr_n   = win_idx;
                    cnt_n   = '0;
                    state_n = GRANTED;
                end
`else
                if (win_valid) begin
                    idx_n   = win_idx;
                    ptr_n   = win_idx;
                    cnt_n   = '0;
                    state_n = GRANTED;
                end
`endif
            end
            GRANTED: begin
                if (frame_low) begin
                    state_n = BUSY;
                end else if (!req_act[idx]) begin
                    state_n = TURNAROUND;
                end else if (cnt == CNT_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = TURNAROUND;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            BUSY: begin
                if (bus_idle) begin
                    state_n = TURNAROUND;
                end
            end
            TURNAROUND: state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    // Output values are decoded from the next state so GNT leaves a flop.
    always_comb begin
        gnt_n  = '1;
        busy_n = (state_n == BUSY);
        case (state_n)
            GRANTED, BUSY: gnt_n[idx_n] = ASSERTED;
`ifdef PCI_ARB_PARKING_EN
            IDLE:          gnt_n[idx_n] = ASSERTED;
`endif
            default:       gnt_n = '1;
        endcase
    end

    assign bus.GNT      = gnt_q;
    assign bus.gnt_idx  = idx;
    assign bus.bus_busy = busy_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed self-checking bench for pci_arbiter with three masters and a 16-clock timeout.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pci_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [2:0] gnt_tab [3];

    pci_arbiter_if #(.N_MASTERS(3)) bus_if ();

    pci_arbiter #(
        .N_MASTERS   (3),
        .GNT_TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [2:0] req, input logic frame, input logic irdy);
        bus_if.REQ   = req;
        bus_if.FRAME = frame;
        bus_if.IRDY  = irdy;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic pulseReset();
        applyStimulus(3'b111, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        gnt_tab[0] = 3'b110;
        gnt_tab[1] = 3'b101;
        gnt_tab[2] = 3'b011;
        rst = 1'b1;
        applyStimulus(3'b111, 1'b1, 1'b1);
        #1;
        checkOutput("rst_gnt",     int'(bus_if.GNT),      int'(3'b111));
        checkOutput("rst_idx",     int'(bus_if.gnt_idx),  0);
        checkOutput("rst_busy",    int'(bus_if.bus_busy), 0);
        checkOutput("rst_timeout", int'(bus_if.timeout),  0);
        step();
        step();
        rst = 1'b0;

        $display("[TB] single master transaction");
        applyStimulus(3'b110, 1'b1, 1'b1);
        step();
        checkOutput("t1_gnt", int'(bus_if.GNT),     int'(3'b110));
        checkOutput("t1_idx", int'(bus_if.gnt_idx), 0);
        applyStimulus(3'b110, 1'b0, 1'b0);
        step();
        checkOutput("t1_busy", int'(bus_if.bus_busy), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b111, 1'b0, 1'b0);
            step();
            checkOutput("t1_hold", int'(bus_if.GNT), int'(3'b110));
        end
        applyStimulus(3'b111, 1'b1, 1'b1);
        step();
        checkOutput("t1_release",   int'(bus_if.GNT),      int'(3'b111));
        checkOutput("t1_busy_done", int'(bus_if.bus_busy), 0);
        step();
        checkOutput("t1_idle", int'(bus_if.GNT), int'(3'b111));

        $display("[TB] round robin with all masters requesting");
        pulseReset();
        applyStimulus(3'b000, 1'b1, 1'b1);
        step();
        for (int t = 0; t < 6; t++) begin
            checkOutput("rr_gnt", int'(bus_if.GNT),     int'(gnt_tab[t % 3]));
            checkOutput("rr_idx", int'(bus_if.gnt_idx), t % 3);
            applyStimulus(3'b000, 1'b0, 1'b0);
            step();
            checkOutput("rr_busy", int'(bus_if.bus_busy), 1);
            applyStimulus(3'b000, 1'b1, 1'b1);
            step();
            checkOutput("rr_turnaround", int'(bus_if.GNT), int'(3'b111));
            step();
            checkOutput("rr_idle_gap", int'(bus_if.GNT), int'(3'b111));
            step();
        end

        $display("[TB] grant timeout");
        pulseReset();
        applyStimulus(3'b101, 1'b1, 1'b1);
        step();
        checkOutput("to_gnt", int'(bus_if.GNT), int'(3'b101));
        for (int i = 1; i < 16; i++) begin
            step();
            checkOutput("to_hold", int'(bus_if.GNT), int'(3'b101));
        end
        checkOutput("to_no_early_pulse", int'(bus_if.timeout), 0);
        applyStimulus(3'b001, 1'b1, 1'b1);
        step();
        checkOutput("to_released", int'(bus_if.GNT),     int'(3'b111));
        checkOutput("to_pulse",    int'(bus_if.timeout), 1);
        checkOutput("to_last_idx", int'(bus_if.gnt_idx), 1);
        step();
        checkOutput("to_pulse_end", int'(bus_if.timeout), 0);
        checkOutput("to_gap",       int'(bus_if.GNT),     int'(3'b111));
        step();
        checkOutput("to_next_gnt", int'(bus_if.GNT),     int'(3'b011));
        checkOutput("to_next_idx", int'(bus_if.gnt_idx), 2);

        $display("[TB] asynchronous reset during a transaction");
        applyStimulus(3'b001, 1'b0, 1'b0);
        step();
        checkOutput("ar_busy", int'(bus_if.bus_busy), 1);
        checkOutput("ar_gnt",  int'(bus_if.GNT),      int'(3'b011));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_gnt_async",  int'(bus_if.GNT),      int'(3'b111));
        checkOutput("ar_busy_async", int'(bus_if.bus_busy), 0);
        applyStimulus(3'b111, 1'b1, 1'b1);
        step();
        step();
        rst = 1'b0;
        applyStimulus(3'b000, 1'b1, 1'b1);
        step();
        checkOutput("ar_first_gnt", int'(bus_if.GNT),     int'(3'b110));
        checkOutput("ar_first_idx", int'(bus_if.gnt_idx), 0);

        $display("[TB] request withdrawn before FRAME");
        applyStimulus(3'b111, 1'b1, 1'b1);
        step();
        checkOutput("wd_gnt",     int'(bus_if.GNT),      int'(3'b111));
        checkOutput("wd_timeout", int'(bus_if.timeout),  0);
        checkOutput("wd_busy",    int'(bus_if.bus_busy), 0);

`ifdef PCI_ARB_PARKING_EN
        $display("[TB] bus parking");
        pulseReset();
        step();
        checkOutput("pk_park", int'(bus_if.GNT), int'(3'b110));
        step();
        step();
        step();
        checkOutput("pk_park_hold", int'(bus_if.GNT), int'(3'b110));
        applyStimulus(3'b101, 1'b1, 1'b1);
        step();
        checkOutput("pk_move_gap", int'(bus_if.GNT), int'(3'b111));
        step();
        checkOutput("pk_move_gnt", int'(bus_if.GNT), int'(3'b101));
        step();
        checkOutput("pk_granted", int'(bus_if.GNT), int'(3'b101));
`else
        $display("[TB] idle bus without parking");
        pulseReset();
        step();
        step();
        step();
        checkOutput("np_idle", int'(bus_if.GNT), int'(3'b111));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
